cpu_controller: RTL and testbench
=================================

# cpu_controller

Multicycle instruction sequencer for the Simple RISC datapath. It takes the instruction register contents and drives every datapath control input: register file, A/B/C/status loads, operand muxes, PC update, branch unit, memory select and write, and IR load. One instruction executes as fetch, PC update, decode, then 1–4 execute states. The block sits beside the datapath in the CPU top level, between `IRout` and the datapath control pins.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock shared with the datapath.
- `reset` input 1: asynchronous, active-low. Forces state RST.
- `ir` input 16: instruction from datapath `IRout`.
  - Fields: op `[15:13]`, sub `[12:11]`, Rn/cond `[10:8]`, Rd `[7:5]`, shift `[4:3]`, Rm `[2:0]`.
- `pc_reset` output 1: drives datapath `reset`, which zeroes PC on the next edge.
- `loadir`, `msel`, `mwrite` outputs 1 each: IR load; address select (1 = C, 0 = PC); RAM write.
- `incp`, `execb`, `tsel` outputs 1 each.
  - `incp` = 1 selects PC+1.
  - `tsel` = 1 selects PC+sximm8; `tsel` = 0 selects A.
- `cond` output 3: branch condition sent to the branch unit.
- `readnum`, `writenum` outputs 3 each: register file read and write indices.
- `write`, `loada`, `loadb`, `loadc`, `loads` outputs 1 each: register and status loads.
- `asel`, `bsel` outputs 1 each: `asel` = 1 forces A to 0; `bsel` = 1 selects sximm5.
- `vsel` output 2: write-back source. 0 = C, 1 = PC, 2 = sximm8, 3 = mdata.
- `shift`, `ALUop` outputs 2 each: taken from `ir[4:3]` and `ir[12:11]` in ALU states, 0 elsewhere.
- `halted` output 1: high in state HALT.

## Operation
- **Moore FSM.** Outputs are decoded from the state register and `ir` only. An output not listed for a state is 0.
- **Fetch and decode.**
  - RST: `pc_reset`=1.
  - IF1: `msel`=0.
  - IF2: `msel`=0, `loadir`=1.
  - UPC: `incp`=1, so PC becomes PC+1.
  - DEC: dispatch on `ir[15:11]`. An unlisted opcode returns to IF1.
- **MOV imm** (11010): MOVI sets `writenum`=Rn, `vsel`=2, `write`=1.
- **MOV reg** (11000): GETB, then ALU with `asel`=1 and `ALUop`=00, then WRC.
- **ALU ops** (101xx):
  - GETA: `readnum`=Rn, `loada`=1.
  - GETB: `readnum`=Rm, `loadb`=1.
  - ALU: `loadc`=1 for 00/10/11; `loads`=1 only for CMP (01).
  - WRC: `writenum`=Rd, `vsel`=0, `write`=1. CMP skips WRC and returns to IF1.
- **LDR** (01100): GETA, then ADDR, then MEM1, then MEM2.
  - ADDR: `bsel`=1, `ALUop`=00, `loadc`=1.
  - MEM1: `msel`=1.
  - MEM2: `msel`=1, `vsel`=3, `writenum`=Rd, `write`=1.
- **STR** (10000): GETA, then ADDR, then GETD, then STORE.
  - GETD: `readnum`=Rd, `loadb`=1.
  - STORE: `msel`=1, `mwrite`=1.
- **B<cond>** (00100): BR sets `execb`=1, `tsel`=1, `incp`=0, `cond`=`ir[10:8]`. The target is (PC+1)+sximm8.
- **BL** (01011): LINK sets `writenum`=7, `vsel`=1, `write`=1. Then BR with `cond` forced to 111.
- **BX** (01000): GETR sets `readnum`=Rd, `loada`=1. Then BRA with `execb`=1, `tsel`=0, `cond`=111.
- **BLX** (01010): GETR, then LINK, then BRA.
  - A is loaded before R7 is written, so BLX R7 jumps to the old R7.
- **HALT** (111xx): enter HALT and stay there. Only `reset` leaves HALT.
- `cond` outputs 0 outside branch states, and `execb` is low there, so no spurious PC update is possible.

## Timing
- **Reset.** Asserting `reset` (low) asynchronously forces state RST, including mid-instruction. All outputs take RST values immediately: `pc_reset`=1, everything else 0.
  - First edge after deassertion: RST → IF1, and PC is cleared on that same edge.
- **Memory.** RAM read data is registered, so the address must be held one edge before `mdata` is used. This is why there are two fetch states (IF1/IF2) and two load states (MEM1/MEM2).
- **Cycles per instruction**, counted from IF1:
  - MOV imm: 5.
  - MOV reg: 7.
  - ADD/AND/MVN: 8.
  - CMP: 7.
  - LDR: 8.
  - STR: 8.
  - B: 5.
  - BL: 6.
  - BX: 6.
  - BLX: 7.
- **Update points.** PC updates only on the UPC edge and the BR/BRA edge (when taken). IR updates only on the IF2 edge.
- **Status.** The status register updates only on the CMP ALU edge. A B<cond> fetched immediately after a CMP sees the new flags.

## Test plan
- Release `reset` → `pc_reset`=1 for one cycle. IR = `0xD007` (MOV R0,#7) → R0=7 five cycles after IF1, `halted`=0.
- MOV R1,#2; MOV R2,#3; ADD R3,R1,R2 LSL#1 → R3=8, status unchanged.
- CMP R1,R1 then BEQ +2 at PC=4 → PC=7 at the next IF1. With R1≠R2, BEQ → PC=5.
- R4=0x20: STR R0,[R4,#1], then LDR R5,[R4,#1] → RAM[0x21]=7, R5=7. `mwrite` is high for exactly one cycle.
- BL +3 at PC=10 → R7=11, PC=14. Then BX R7 → PC=11. BLX R7 with R7=11 at PC=20 → PC=11, R7=21.
- HALT → `halted` stays 1 for 20 cycles with PC frozen. Pull `reset` low mid-LDR (MEM1) → outputs go to RST values within the same cycle.

Source files
------------

// File: rtl/cpu_controller.sv
// Multicycle instruction sequencer for the Simple RISC datapath.
// Walks fetch/PC-update/decode/execute states and drives all datapath control pins from registered outputs.
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  output logic        pc_reset,
  output logic        loadir,
  output logic        msel,
  output logic        mwrite,
  output logic        incp,
  output logic        execb,
  output logic        tsel,
  output logic [2:0]  cond,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        halted
);

  localparam int unsigned STATE_W = 5;

  localparam logic [4:0] OPC_MOVI = 5'b11010;
  localparam logic [4:0] OPC_MOVR = 5'b11000;
  localparam logic [4:0] OPC_LDR  = 5'b01100;
  localparam logic [4:0] OPC_STR  = 5'b10000;
  localparam logic [4:0] OPC_B    = 5'b00100;
  localparam logic [4:0] OPC_BL   = 5'b01011;
  localparam logic [4:0] OPC_BX   = 5'b01000;
  localparam logic [4:0] OPC_BLX  = 5'b01010;
  localparam logic [2:0] OP_ALU   = 3'b101;
  localparam logic [2:0] OP_HALT  = 3'b111;
  localparam logic [2:0] OP_MOVR  = 3'b110;

  localparam logic [1:0] VSEL_C     = 2'd0;
  localparam logic [1:0] VSEL_PC    = 2'd1;
  localparam logic [1:0] VSEL_IMM8  = 2'd2;
  localparam logic [1:0] VSEL_MDATA = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
    S_MOVI, S_GETA, S_GETB, S_ALU, S_WRC,
    S_ADDR, S_MEM1, S_MEM2, S_GETD, S_STORE,
    S_BR, S_LINK, S_GETR, S_BRA, S_HALT
  } state_t;

  state_t state, state_nxt;

  logic [4:0] opc;
  logic [2:0] op;
  logic [1:0] sub;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;
  logic       is_cmp;

  assign opc    = ir[15:11];
  assign op     = ir[15:13];
  assign sub    = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign is_cmp = (op == OP_ALU) && (sub == 2'b01);

  // Next-state: shared execute states branch on the opcode still held in IR.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:  state_nxt = S_IF1;
      S_IF1:  state_nxt = S_IF2;
      S_IF2:  state_nxt = S_UPC;
      S_UPC:  state_nxt = S_DEC;
      S_DEC: begin
        if (opc == OPC_MOVI)                         state_nxt = S_MOVI;
        else if (opc == OPC_MOVR)                    state_nxt = S_GETB;
        else if (op == OP_ALU)                       state_nxt = S_GETA;
        else if (opc == OPC_LDR || opc == OPC_STR)   state_nxt = S_GETA;
        else if (opc == OPC_B)                       state_nxt = S_BR;
        else if (opc == OPC_BL)                      state_nxt = S_LINK;
        else if (opc == OPC_BX || opc == OPC_BLX)    state_nxt = S_GETR;
        else if (op == OP_HALT)                      state_nxt = S_HALT;
        else                                         state_nxt = S_IF1;
      end
      S_MOVI: state_nxt = S_IF1;
      S_GETA: state_nxt = (opc == OPC_LDR || opc == OPC_STR) ? S_ADDR : S_GETB;
      S_GETB: state_nxt = S_ALU;
      S_ALU:  state_nxt = is_cmp ? S_IF1 : S_WRC;
      S_WRC:  state_nxt = S_IF1;
      S_ADDR: state_nxt = (opc == OPC_LDR) ? S_MEM1 : S_GETD;
      S_MEM1: state_nxt = S_MEM2;
      S_MEM2: state_nxt = S_IF1;
      S_GETD: state_nxt = S_STORE;
      S_STORE: state_nxt = S_IF1;
      S_BR:   state_nxt = S_IF1;
      S_LINK: state_nxt = (opc == OPC_BLX) ? S_BRA : S_BR;
      S_GETR: state_nxt = (opc == OPC_BLX) ? S_LINK : S_BRA;
      S_BRA:  state_nxt = S_IF1;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  logic       pc_reset_d, loadir_d, msel_d, mwrite_d, incp_d, execb_d, tsel_d;
  logic [2:0] cond_d, readnum_d, writenum_d;
  logic       write_d, loada_d, loadb_d, loadc_d, loads_d, asel_d, bsel_d;
  logic [1:0] vsel_d, shift_d, aluop_d;
  logic       halted_d;

  // Output decode of the state being entered; IR is stable across every edge whose target uses it.
  always_comb begin
    pc_reset_d = 1'b0;
    loadir_d   = 1'b0;
    msel_d     = 1'b0;
    mwrite_d   = 1'b0;
    incp_d     = 1'b0;
    execb_d    = 1'b0;
    tsel_d     = 1'b0;
    cond_d     = 3'd0;
    readnum_d  = 3'd0;
    writenum_d = 3'd0;
    write_d    = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    asel_d     = 1'b0;
    bsel_d     = 1'b0;
    vsel_d     = VSEL_C;
    shift_d    = 2'd0;
    aluop_d    = 2'd0;
    halted_d   = 1'b0;
    case (state_nxt)
      S_RST: pc_reset_d = 1'b1;
      S_IF2: loadir_d = 1'b1;
      S_UPC: incp_d = 1'b1;
      S_MOVI: begin
        writenum_d = rn;
        vsel_d     = VSEL_IMM8;
        write_d    = 1'b1;
      end
      S_GETA: begin
        readnum_d = rn;
        loada_d   = 1'b1;
      end
      S_GETB: begin
        readnum_d = rm;
        loadb_d   = 1'b1;
      end
      S_ALU: begin
        shift_d = sh;
        aluop_d = sub;
        asel_d  = (op == OP_MOVR);
        loadc_d = !is_cmp;
        loads_d = is_cmp;
      end
      S_WRC: begin
        writenum_d = rd;
        vsel_d     = VSEL_C;
        write_d    = 1'b1;
      end
      S_ADDR: begin
        bsel_d  = 1'b1;
        loadc_d = 1'b1;
      end
      S_MEM1: msel_d = 1'b1;
      S_MEM2: begin
        msel_d     = 1'b1;
        vsel_d     = VSEL_MDATA;
        writenum_d = rd;
        write_d    = 1'b1;
      end
      S_GETD: begin
        readnum_d = rd;
        loadb_d   = 1'b1;
      end
      S_STORE: begin
        msel_d   = 1'b1;
        mwrite_d = 1'b1;
      end
      S_BR: begin
        execb_d = 1'b1;
        tsel_d  = 1'b1;
        cond_d  = (opc == OPC_BL) ? 3'b111 : rn;
      end
      S_LINK: begin
        writenum_d = 3'd7;
        vsel_d     = VSEL_PC;
        write_d    = 1'b1;
      end
      S_GETR: begin
        readnum_d = rd;
        loada_d   = 1'b1;
      end
      S_BRA: begin
        execb_d = 1'b1;
        cond_d  = 3'b111;
      end
      S_HALT: halted_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers; reset lands in RST with its outputs immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_RST;
      pc_reset <= 1'b1;
      loadir   <= 1'b0;
      msel     <= 1'b0;
      mwrite   <= 1'b0;
      incp     <= 1'b0;
      execb    <= 1'b0;
      tsel     <= 1'b0;
      cond     <= 3'd0;
      readnum  <= 3'd0;
      writenum <= 3'd0;
      write    <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      bsel     <= 1'b0;
      vsel     <= 2'd0;
      shift    <= 2'd0;
      ALUop    <= 2'd0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_reset <= pc_reset_d;
      loadir   <= loadir_d;
      msel     <= msel_d;
      mwrite   <= mwrite_d;
      incp     <= incp_d;
      execb    <= execb_d;
      tsel     <= tsel_d;
      cond     <= cond_d;
      readnum  <= readnum_d;
      writenum <= writenum_d;
      write    <= write_d;
      loada    <= loada_d;
      loadb    <= loadb_d;
      loadc    <= loadc_d;
      loads    <= loads_d;
      asel     <= asel_d;
      bsel     <= bsel_d;
      vsel     <= vsel_d;
      shift    <= shift_d;
      ALUop    <= aluop_d;
      halted   <= halted_d;
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: steps each instruction class cycle by cycle
// and compares every control output against hand-derived values.
module tb_cpu_controller;

  logic        clk;
  logic        reset;
  logic [15:0] ir;
  logic        pc_reset, loadir, msel, mwrite, incp, execb, tsel;
  logic [2:0]  cond, readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, shift, ALUop;
  logic        halted;

  typedef struct packed {
    logic       pc_reset, loadir, msel, mwrite, incp, execb, tsel;
    logic [2:0] cond, readnum, writenum;
    logic       write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] vsel, shift, aluop;
    logic       halted;
  } ctl_t;

  ctl_t obs;
  int   n_cmp  = 0;
  int   n_fail = 0;

  cpu_controller dut (
    .clk(clk), .reset(reset), .ir(ir),
    .pc_reset(pc_reset), .loadir(loadir), .msel(msel), .mwrite(mwrite),
    .incp(incp), .execb(execb), .tsel(tsel), .cond(cond),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .halted(halted)
  );

  assign obs = {pc_reset, loadir, msel, mwrite, incp, execb, tsel,
                cond, readnum, writenum,
                write, loada, loadb, loadc, loads, asel, bsel,
                vsel, shift, ALUop, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input ctl_t e);
    n_cmp++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Check the current cycle, then advance one cycle.
  task automatic st(input string tag, input ctl_t e);
    chk(tag, e);
    tick();
  endtask

  function automatic ctl_t e_zero();
    ctl_t e;
    e = '0;
    return e;
  endfunction

  function automatic ctl_t e_rst();
    ctl_t e;
    e = '0;
    e.pc_reset = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_lda(input logic [2:0] n);
    ctl_t e;
    e = '0;
    e.readnum = n;
    e.loada   = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_ldb(input logic [2:0] n);
    ctl_t e;
    e = '0;
    e.readnum = n;
    e.loadb   = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_wr(input logic [2:0] n, input logic [1:0] v);
    ctl_t e;
    e = '0;
    e.writenum = n;
    e.vsel     = v;
    e.write    = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_alu(input logic [1:0] op, input logic [1:0] sh,
                                 input logic c, input logic s, input logic a);
    ctl_t e;
    e = '0;
    e.aluop = op;
    e.shift = sh;
    e.loadc = c;
    e.loads = s;
    e.asel  = a;
    return e;
  endfunction

  function automatic ctl_t e_br(input logic [2:0] c, input logic t);
    ctl_t e;
    e = '0;
    e.execb = 1'b1;
    e.tsel  = t;
    e.cond  = c;
    return e;
  endfunction

  // Starts at IF1 (sampled), loads ir, and returns sampling the first execute state.
  task automatic fetch(input logic [15:0] instr, input string tag);
    ctl_t e;
    chk({tag, "_if1"}, e_zero());
    ir = instr;
    tick();
    e = '0; e.loadir = 1'b1;
    st({tag, "_if2"}, e);
    e = '0; e.incp = 1'b1;
    st({tag, "_upc"}, e);
    st({tag, "_dec"}, e_zero());
  endtask

  initial begin
    ctl_t e;
    reset = 1'b1;
    ir    = 16'h0000;
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_hold0", e_rst());
    tick();
    chk("reset_hold1", e_rst());
    reset = 1'b1;
    tick();

    // MOV R0,#7
    fetch(16'hD007, "movi");
    st("movi_ex", e_wr(3'd0, 2'd2));

    // ADD R3,R1,R2 LSL#1
    fetch(16'hA16A, "add");
    st("add_geta", e_lda(3'd1));
    st("add_getb", e_ldb(3'd2));
    st("add_alu",  e_alu(2'b00, 2'b01, 1'b1, 1'b0, 1'b0));
    st("add_wrc",  e_wr(3'd3, 2'd0));

    // CMP R1,R1: no write-back, status load only
    fetch(16'hA901, "cmp");
    st("cmp_geta", e_lda(3'd1));
    st("cmp_getb", e_ldb(3'd1));
    st("cmp_alu",  e_alu(2'b01, 2'b00, 1'b0, 1'b1, 1'b0));

    // BEQ +2
    fetch(16'h2102, "beq");
    st("beq_br", e_br(3'b001, 1'b1));

    // MOV R1,R2 (register form)
    fetch(16'hC022, "movr");
    st("movr_getb", e_ldb(3'd2));
    st("movr_alu",  e_alu(2'b00, 2'b00, 1'b1, 1'b0, 1'b1));
    st("movr_wrc",  e_wr(3'd1, 2'd0));

    // AND R2,R3,R4
    fetch(16'hB344, "and");
    st("and_geta", e_lda(3'd3));
    st("and_getb", e_ldb(3'd4));
    st("and_alu",  e_alu(2'b10, 2'b00, 1'b1, 1'b0, 1'b0));
    st("and_wrc",  e_wr(3'd2, 2'd0));

    // STR R0,[R4,#1]
    fetch(16'h8401, "str");
    st("str_geta", e_lda(3'd4));
    e = '0; e.bsel = 1'b1; e.loadc = 1'b1;
    st("str_addr", e);
    st("str_getd", e_ldb(3'd0));
    e = '0; e.msel = 1'b1; e.mwrite = 1'b1;
    st("str_store", e);

    // LDR R5,[R4,#1]
    fetch(16'h64A1, "ldr");
    st("ldr_geta", e_lda(3'd4));
    e = '0; e.bsel = 1'b1; e.loadc = 1'b1;
    st("ldr_addr", e);
    e = '0; e.msel = 1'b1;
    st("ldr_mem1", e);
    e = e_wr(3'd5, 2'd3); e.msel = 1'b1;
    st("ldr_mem2", e);

    // BL +3 with a non-111 Rn field: cond must still be 111
    fetch(16'h5803, "bl");
    st("bl_link", e_wr(3'd7, 2'd1));
    st("bl_br",   e_br(3'b111, 1'b1));

    // BX R7
    fetch(16'h40E0, "bx");
    st("bx_getr", e_lda(3'd7));
    st("bx_bra",  e_br(3'b111, 1'b0));

    // BLX R7: A loaded before link write
    fetch(16'h50E0, "blx");
    st("blx_getr", e_lda(3'd7));
    st("blx_link", e_wr(3'd7, 2'd1));
    st("blx_bra",  e_br(3'b111, 1'b0));

    // Unlisted opcode falls straight back to IF1
    fetch(16'h0000, "undef");

    // HALT holds for 20 cycles
    fetch(16'hE000, "halt");
    e = '0; e.halted = 1'b1;
    for (int i = 0; i < 20; i++) st("halt_hold", e);

    // Async reset out of HALT
    #2 reset = 1'b0;
    #1 chk("halt_reset_async", e_rst());
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Reset asserted mid-LDR in MEM1
    fetch(16'h64A1, "ldr2");
    st("ldr2_geta", e_lda(3'd4));
    e = '0; e.bsel = 1'b1; e.loadc = 1'b1;
    st("ldr2_addr", e);
    e = '0; e.msel = 1'b1;
    chk("ldr2_mem1", e);
    #2 reset = 1'b0;
    #1 chk("ldr2_reset_async", e_rst());
    @(negedge clk);
    chk("ldr2_reset_hold", e_rst());
    reset = 1'b1;
    tick();

    // Recovery after reset
    fetch(16'hD007, "movi2");
    st("movi2_ex", e_wr(3'd0, 2'd2));
    chk("final_if1", e_zero());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
